// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the scoreboarded register file.
// Latency: n/a (compile-time constants and a helper function only).
// Backpressure: n/a.
package reg_file_pkg;

   localparam int DEF_DATA_W = 32;  // register width in bits
   localparam int DEF_ADDR_W = 5;   // address width
   localparam int DEF_NUM_RD = 2;   // independent read ports (1..4)

   // Number of architectural registers addressed by an aw-bit index.
   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

   localparam int DEF_DEPTH = depth_of(DEF_ADDR_W);

endpackage

// File: rtl/reg_busy_sb.sv
// Busy-bit scoreboard: one pending-write flag per register, register 0 never busy.
// Latency: resv_accept is combinational; busy bits update on the next core_clk edge.
// Backpressure: a reservation of an already-busy register is refused (resv_accept=0).
//
// Ports:
//   core_clk, arst_n         clock, async active-low reset (clears every busy bit)
//   resv_reg, resv_valid     reservation request for one register
//   resv_accept              reservation granted this cycle
//   write_reg, write_en      register write-back, clears that register's busy bit
//   busy_vec                 full busy vector, bit i = register i pending
module reg_busy_sb
   import reg_file_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = depth_of(DEF_ADDR_W)
) (
   input  logic              core_clk,
   input  logic              arst_n,
   input  logic [ADDR_W-1:0] resv_reg,
   input  logic              resv_valid,
   output logic              resv_accept,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic              write_en,
   output logic [DEPTH-1:0]  busy_vec
);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_nxt;
   logic             set_hit;
   logic             clr_hit;

   // Register 0 is never busy, so a reservation of r0 is always granted.
   assign resv_accept = resv_valid & ~busy[resv_reg];
   assign set_hit     = resv_accept & (resv_reg != '0);
   assign clr_hit     = write_en & (write_reg != '0);

   // Clear applied before set: a reservation and a write-back of the same
   // register on one edge leaves it busy (the new reservation is pending).
   always_comb begin
      busy_nxt = busy;
      if (clr_hit) busy_nxt[write_reg] = 1'b0;
      if (set_hit) busy_nxt[resv_reg]  = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) busy <= '0;
      else         busy <= busy_nxt;
   end

   assign busy_vec = busy;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with register-0 hardwired to zero and a busy-bit scoreboard.
// Latency: reads and ResvAccept are combinational; writes/reservations land on the rising Clock edge.
// Backpressure: ResvAccept deasserts when the requested register already has a pending write.
//
// Ports:
//   Clock, Reset                 clock, async active-low reset (clears data and busy bits)
//   ReadReg/ReadData/ReadBusy    NUM_RD packed read ports, port k at slice k
//   WriteReg/WriteData/Reg_write_Control   write port, also clears the busy bit
//   ResvReg/ResvValid/ResvAccept reservation (mark register pending)
//   BusyVec                      full busy vector
// Build option: define REG_FILE_SB_BYPASS_EN to forward same-cycle write data
// (and a cleared busy flag) to read ports addressing the register being written.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = DEF_NUM_RD
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [NUM_RD*ADDR_W-1:0] ReadReg,
   output logic [NUM_RD*DATA_W-1:0] ReadData,
   output logic [NUM_RD-1:0]        ReadBusy,
   input  logic [ADDR_W-1:0]        WriteReg,
   input  logic [DATA_W-1:0]        WriteData,
   input  logic                     Reg_write_Control,
   input  logic [ADDR_W-1:0]        ResvReg,
   input  logic                     ResvValid,
   output logic                     ResvAccept,
   output logic [(1<<ADDR_W)-1:0]   BusyVec
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_hit;

   assign wr_hit = Reg_write_Control & (WriteReg != '0);

   // Entry 0 is reset and never written, so it always reads back zero.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_hit) begin
         regs[WriteReg] <= WriteData;
      end
   end

   reg_busy_sb #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_busy (
      .core_clk    (Clock),
      .arst_n      (Reset),
      .resv_reg    (ResvReg),
      .resv_valid  (ResvValid),
      .resv_accept (ResvAccept),
      .write_reg   (WriteReg),
      .write_en    (Reg_write_Control),
      .busy_vec    (BusyVec)
   );

`ifdef REG_FILE_SB_BYPASS_EN
   // Forwarding is held off during reset so outputs read as zero there.
   logic bypass_hit;
   assign bypass_hit = wr_hit & Reset;
`endif

   always_comb begin
      logic [ADDR_W-1:0] addr;
      addr     = '0;
      ReadData = '0;
      ReadBusy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         addr = ReadReg[k*ADDR_W +: ADDR_W];
         ReadData[k*DATA_W +: DATA_W] = regs[addr];
         ReadBusy[k]                  = BusyVec[addr];
`ifdef REG_FILE_SB_BYPASS_EN
         if (bypass_hit && (addr == WriteReg)) begin
            ReadData[k*DATA_W +: DATA_W] = WriteData;
            ReadBusy[k]                  = 1'b0;
         end
`endif
      end
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ReadReg  input  NUM_RD*ADDR_W  packed read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-007 SHALL have port ReadData  output  NUM_RD*DATA_W  packed read data, port k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port ReadBusy  output  NUM_RD  per-port busy flag of the addressed register.
REQ-009 SHALL have port WriteReg  input  ADDR_W  write address.
REQ-010 SHALL have port WriteData  input  DATA_W  write data.
REQ-011 SHALL have port Reg_write_Control  input  1  write enable.
REQ-012 SHALL have port ResvReg  input  ADDR_W  register to reserve (mark pending write).
REQ-013 SHALL have port ResvValid  input  1  reservation request.
REQ-014 SHALL have port ResvAccept  output  1  reservation granted this cycle.
REQ-015 SHALL have port BusyVec  output  DEPTH  full busy-bit vector, bit i = register i pending.

Function
REQ-016 SHALL read combinationally: ReadData port k = reg[ReadReg k], zero latency, all ports independent and simultaneous.
REQ-017 SHALL write reg[WriteReg] <= WriteData on rising Clock when Reg_write_Control=1 and WriteReg!=0.
REQ-018 SHALL hardwire register 0: reads return 0, writes ignored, busy bit always 0.
REQ-019 SHALL drive ResvAccept = ResvValid & !busy[ResvReg] combinationally; a reservation of register 0 is always accepted and has no effect.
REQ-020 SHALL set busy[ResvReg] on the rising edge when ResvAccept=1 and ResvReg!=0.
REQ-021 SHALL clear busy[WriteReg] on the rising edge when Reg_write_Control=1, unless the same edge sets it by an accepted reservation (set wins).
REQ-022 SHALL allow writes to non-busy registers; the busy bit stays 0.
REQ-023 SHALL drive ReadBusy port k = busy[ReadReg k], subject to REQ-026.
REQ-024 SHALL handle reservation and write to different registers in the same cycle independently.

Reset
REQ-025 SHALL, while Reset=0, immediately clear all registers and busy bits, regardless of Clock; outputs: ReadData=0, ReadBusy=0, BusyVec=0, and ResvAccept=ResvValid. A write or reservation in flight at reset assertion SHALL be discarded.

Configuration
REQ-026 SHALL honour macro REG_FILE_SB_BYPASS_EN: when defined, a read port whose ReadReg equals WriteReg (nonzero) while Reg_write_Control=1 returns WriteData and ReadBusy=0 in the same cycle; when undefined, it returns the stored value and stored busy bit.

Structure
REQ-027 SHALL place DATA_W/ADDR_W/NUM_RD defaults and the DEPTH derivation constant in shared package reg_file_pkg.
REQ-028 SHALL implement busy-bit tracking (REQ-019..021) in one sub-module reg_busy_sb; storage and read muxing stay in the top.

Verification
REQ-029 SHALL cover reset: Reset=0 mid-write of 32'h12345678 to r3 -> after release r3 reads 0, BusyVec=0.
REQ-030 SHALL cover r0: write 32'hDEADBEEF to r0, reserve r0 -> ReadData(r0)=0, ResvAccept=1, BusyVec[0]=0.
REQ-031 SHALL cover multi-port read: write r1=32'h9ABCDEF0, r2=32'h00000002 -> ports 0/1 reading r1/r2 same cycle return those values.
REQ-032 SHALL cover scoreboard: reserve r5 -> BusyVec[5]=1; second reserve r5 -> ResvAccept=0; write r5=32'h5 -> BusyVec[5]=0 next edge.
REQ-033 SHALL cover same-edge set/clear: r7 not busy, reserve r7 and write r7=32'h7 same cycle -> r7=32'h7, BusyVec[7]=1.
REQ-034 SHALL cover bypass: write r4=32'hA5A5A5A5 while ReadReg0=4 -> ReadData0=32'hA5A5A5A5 same cycle with REG_FILE_SB_BYPASS_EN, old value without.
